// File: rtl/polaris_pkg.sv
// polaris_pkg: shared arbiter state encoding, transfer sizes and bus widths
package polaris_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;
  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;
  localparam logic [1:0] SIZE_DWORD = 2'd3;
  localparam int ADR_W = 64;
  localparam int DAT_W = 16;
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: 8-bit stall counter that flags the cycle an owner hits TIMEOUT
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);
  localparam logic [7:0] LIM = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? 8'd0 : en_i ? cnt_q + 8'd1 : cnt_q;
  // the pulse fires in the cycle whose stall would bring the count to TIMEOUT
  assign timeout_o = (TIMEOUT != 0) && en_i && (cnt_q == LIM);
  always_ff @(posedge clk_i) begin
    cnt_q <= !reset_ni ? 8'd0 : cnt_d;
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin bus arbiter with watchdog release
module bus_arbiter
  import polaris_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             m0_req_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [1:0]       m0_size_i,
  input  logic             m0_we_i,
  input  logic             m0_vpa_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic             m0_gnt_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic             m1_req_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [1:0]       m1_size_i,
  input  logic             m1_we_i,
  input  logic             m1_vpa_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic             m1_gnt_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             cyc_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [1:0]       size_o,
  output logic             we_o,
  output logic             vpa_o,
  output logic [DAT_W-1:0] dat_o,
  input  logic             ack_i,
  input  logic [DAT_W-1:0] dat_i
);
  state_e     state_q;
  logic       last_q;
  logic [1:0] blk_q;
  logic       own0, own1, ack_fwd, tmo, el0, el1;
  assign own0     = state_q == OWN0;
  assign own1     = state_q == OWN1;
  assign m0_gnt_o = own0;
  assign m1_gnt_o = own1;
  assign cyc_o    = own0 ? m0_req_i  : own1 ? m1_req_i  : 1'b0;
  assign adr_o    = own0 ? m0_adr_i  : own1 ? m1_adr_i  : '0;
  assign size_o   = own0 ? m0_size_i : own1 ? m1_size_i : '0;
  assign we_o     = own0 ? m0_we_i   : own1 ? m1_we_i   : 1'b0;
  assign vpa_o    = own0 ? m0_vpa_i  : own1 ? m1_vpa_i  : 1'b0;
  assign dat_o    = own0 ? m0_dat_i  : own1 ? m1_dat_i  : '0;
  assign ack_fwd  = cyc_o & ack_i;
  assign m0_ack_o = own0 & ack_fwd;
  assign m1_ack_o = own1 & ack_fwd;
  assign m0_err_o = own0 & tmo;
  assign m1_err_o = own1 & tmo;
  assign m0_dat_o = dat_i;
  assign m1_dat_o = dat_i;
  assign el0      = m0_req_i & ~blk_q[0];
  assign el1      = m1_req_i & ~blk_q[1];
  // clearing throughout IDLE guarantees a fresh count on every tenure entry
  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (~(own0 | own1) | ack_fwd),
    .en_i     (cyc_o & ~ack_i),
    .timeout_o(tmo)
  );
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      blk_q   <= 2'b00;
    end else begin
      blk_q <= (blk_q & {m1_req_i, m0_req_i}) | {m1_err_o, m0_err_o};
      case (state_q)
        OWN0: if (!m0_req_i || tmo) begin
          state_q <= IDLE;
          last_q  <= 1'b0;
        end
        OWN1: if (!m1_req_i || tmo) begin
          state_q <= IDLE;
          last_q  <= 1'b1;
        end
        default: state_q <= (el0 && (!el1 || last_q)) ? OWN0 : el1 ? OWN1 : IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scoreboard bench for bus_arbiter with TIMEOUT=4
module tb_bus_arbiter;
  logic        clk_i = 1'b0, reset_ni = 1'b0;
  logic        m0_req_i = 0, m0_we_i = 0, m0_vpa_i = 0;
  logic [63:0] m0_adr_i = '0;
  logic [1:0]  m0_size_i = '0;
  logic [15:0] m0_dat_i = '0;
  logic        m1_req_i = 0, m1_we_i = 0, m1_vpa_i = 0;
  logic [63:0] m1_adr_i = '0;
  logic [1:0]  m1_size_i = '0;
  logic [15:0] m1_dat_i = '0;
  logic        ack_i = 0;
  logic [15:0] dat_i = '0;
  logic        m0_gnt_o, m0_ack_o, m0_err_o, m1_gnt_o, m1_ack_o, m1_err_o;
  logic [15:0] m0_dat_o, m1_dat_o, dat_o;
  logic        cyc_o, we_o, vpa_o;
  logic [63:0] adr_o;
  logic [1:0]  size_o;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b0100000, A0 = 7'b0010000,
                         A1 = 7'b0001000, E0 = 7'b0000100, E1 = 7'b0000010,
                         CY = 7'b0000001;

  typedef struct {
    string        tag;
    logic [122:0] v;
  } exp_t;
  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0;

  bus_arbiter #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .m0_req_i(m0_req_i), .m0_adr_i(m0_adr_i), .m0_size_i(m0_size_i),
    .m0_we_i(m0_we_i), .m0_vpa_i(m0_vpa_i), .m0_dat_i(m0_dat_i),
    .m0_gnt_o(m0_gnt_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_req_i(m1_req_i), .m1_adr_i(m1_adr_i), .m1_size_i(m1_size_i),
    .m1_we_i(m1_we_i), .m1_vpa_i(m1_vpa_i), .m1_dat_i(m1_dat_i),
    .m1_gnt_o(m1_gnt_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .cyc_o(cyc_o), .adr_o(adr_o), .size_o(size_o), .we_o(we_o), .vpa_o(vpa_o),
    .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [83:0] bus_of(int o);
    return o == 0 ? {m0_size_i, m0_we_i, m0_vpa_i, m0_dat_i, m0_adr_i}
         : o == 1 ? {m1_size_i, m1_we_i, m1_vpa_i, m1_dat_i, m1_adr_i} : 84'd0;
  endfunction

  // Push the expectation for the current inputs, sample at the falling edge,
  // then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [6:0] ctl, input int o);
    exp_t e, p;
    logic [122:0] obs;
    e.tag = tag;
    e.v = {ctl, bus_of(o), dat_i, dat_i};
    exp_q.push_back(e);
    @(negedge clk_i);
    obs = {m0_gnt_o, m1_gnt_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, cyc_o,
           size_o, we_o, vpa_o, dat_o, adr_o, m0_dat_o, m1_dat_o};
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      p = exp_q.pop_front();
      n_vec++;
      assert (obs === p.v) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", p.tag, obs, p.v);
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    m0_adr_i = 64'hFFFF_FFFF_FFFF_FF00; m0_size_i = 2'd3; m0_we_i = 1; m0_vpa_i = 1;
    m0_dat_i = 16'hBEEF;
    m1_adr_i = 64'h0000_0000_1000_0040; m1_size_i = 2'd2; m1_we_i = 0; m1_vpa_i = 0;
    m1_dat_i = 16'h5A5A;
    dat_i = 16'h0000;
    @(posedge clk_i); #1;
    cyc("rst", 7'd0, -1);
    reset_ni = 1;
    dat_i = 16'hC3A5;
    // single master, two acked beats, then release
    m0_req_i = 1;
    cyc("t1_idle", 7'd0, -1);
    ack_i = 1;
    cyc("t1_beat1", G0 | CY | A0, 0);
    cyc("t1_beat2", G0 | CY | A0, 0);
    ack_i = 0; m0_req_i = 0;
    cyc("t1_drop", G0, 0);
    ack_i = 1;
    cyc("t1_idle_ack", 7'd0, -1);
    ack_i = 0;
    // contention right after reset: m0 first, then m1 after one IDLE cycle
    reset_ni = 0;
    cyc("rst2", 7'd0, -1);
    reset_ni = 1;
    m0_req_i = 1; m1_req_i = 1;
    cyc("t2_contend", 7'd0, -1);
    cyc("t2_g0", G0 | CY, 0);
    m0_req_i = 0;
    cyc("t2_drop0", G0, 0);
    cyc("t2_gap", 7'd0, -1);
    cyc("t2_g1", G1 | CY, 1);
    ack_i = 1;
    cyc("t2_ack1", G1 | CY | A1, 1);
    ack_i = 0; m1_req_i = 0;
    cyc("t2_rel1", G1, 1);
    cyc("t2_idle", 7'd0, -1);
    // watchdog timeout on m1 and blocking until req drops
    m1_req_i = 1;
    cyc("t3_idle", 7'd0, -1);
    cyc("t3_c1", G1 | CY, 1);
    cyc("t3_c2", G1 | CY, 1);
    cyc("t3_c3", G1 | CY, 1);
    cyc("t3_err", G1 | CY | E1, 1);
    cyc("t3_blk1", 7'd0, -1);
    cyc("t3_blk2", 7'd0, -1);
    m1_req_i = 0;
    cyc("t3_low", 7'd0, -1);
    m1_req_i = 1;
    cyc("t3_reidle", 7'd0, -1);
    cyc("t3_regrant", G1 | CY, 1);
    // ack in the would-be timeout cycle wins
    cyc("t4_c2", G1 | CY, 1);
    cyc("t4_c3", G1 | CY, 1);
    ack_i = 1;
    cyc("t4_ack", G1 | CY | A1, 1);
    ack_i = 0;
    cyc("t4_cont", G1 | CY, 1);
    m1_req_i = 0;
    cyc("t4_rel", G1, 1);
    cyc("t4_idle", 7'd0, -1);
    // reset in the middle of an m0 tenure
    m0_req_i = 1;
    cyc("t5_idle", 7'd0, -1);
    cyc("t5_own", G0 | CY, 0);
    reset_ni = 0;
    cyc("t5_rst_edge", G0 | CY, 0);
    reset_ni = 1; m1_req_i = 1;
    cyc("t5_after", 7'd0, -1);
    cyc("t5_g0", G0 | CY, 0);
    m0_req_i = 0;
    cyc("t5_drop0", G0, 0);
    cyc("t5_gap", 7'd0, -1);
    cyc("t5_g1", G1 | CY, 1);
    m1_req_i = 0;
    cyc("t5_rel1", G1, 1);
    cyc("t5_end", 7'd0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 255, cycles without ack_i before an owner is forcibly released (0 disables; max 255).
REQ-002 clk_i  input  1  sole clock, all state on rising edge.
REQ-003 reset_ni  input  1  reset, synchronous, active-low.
REQ-004 mN_req_i  input  1  master N (0=fetch, 1=data) requests and holds the bus.
REQ-005 mN_adr_i  input  64  master N byte address.
REQ-006 mN_size_i  input  2  master N transfer size (0=byte, 1=half, 2=word, 3=dword).
REQ-007 mN_we_i  input  1  master N write enable.
REQ-008 mN_vpa_i  input  1  master N valid program address (instruction fetch).
REQ-009 mN_dat_i  input  16  master N write data.
REQ-010 mN_gnt_o  output  1  master N owns the bus (registered).
REQ-011 mN_ack_o  output  1  ack_i forwarded to owner only.
REQ-012 mN_err_o  output  1  one-cycle watchdog timeout pulse to owner.
REQ-013 mN_dat_o  output  16  dat_i broadcast to both masters.
REQ-014 cyc_o  output  1  bus cycle valid.
REQ-015 adr_o / size_o / we_o / vpa_o / dat_o  output  64/2/1/1/16  muxed owner fields.
REQ-016 ack_i  input  1  slave acknowledge.  dat_i  input  16  slave read data.

Function
REQ-017 States SHALL be IDLE, OWN0, OWN1; mN_gnt_o SHALL equal (state==OWNN).
REQ-018 IDLE: cyc_o, adr_o, size_o, we_o, vpa_o, dat_o SHALL be 0; ack_i ignored.
REQ-019 IDLE with one eligible requester SHALL enter its OWN state next cycle (one-cycle grant latency).
REQ-020 IDLE with both eligible SHALL grant the master not served last (round-robin); "last" resets to 1 so m0 wins first.
REQ-021 OWNN: bus outputs SHALL combinationally follow master N's inputs; cyc_o = mN_req_i.
REQ-022 OWNN: mN_ack_o = ack_i & mN_req_i in the same cycle; other master's ack_o SHALL be 0.
REQ-023 Owner SHALL keep the bus across any number of acked beats while mN_req_i stays high.
REQ-024 OWNN with mN_req_i low SHALL return to IDLE next cycle and set last=N; ack_i that cycle ignored.
REQ-025 Every tenure SHALL be followed by at least one IDLE cycle (no direct handoff).
REQ-026 Watchdog: 8-bit counter cleared on entry to OWN and on every forwarded ack; increments each OWN cycle with req high and no ack.
REQ-027 When counter reaches TIMEOUT (nonzero), mN_err_o SHALL pulse one cycle, state SHALL go IDLE, last=N, master N marked blocked.
REQ-028 Blocked master SHALL be ineligible until its req is sampled low; block clears that cycle.
REQ-029 ack_i coincident with the timeout cycle SHALL win: forwarded, counter cleared, no error.

Reset
REQ-030 On reset_ni low at a clock edge: state=IDLE, last=1, counter=0, blocked flags=0, all outputs 0 from the next cycle, mid-tenure included.

Structure
REQ-031 State encoding and SIZE_* constants SHALL live in shared package polaris_pkg.
REQ-032 Watchdog SHALL be one sub-module, bus_watchdog (counter, clear, enable, timeout pulse).

Verification
REQ-033 m0_req only, adr 0xFFFF_FFFF_FFFF_FF00, two acks, drop req -> m0_gnt_o 1 cycle after req, adr_o matches, two m0_ack_o, IDLE 1 cycle after drop.
REQ-034 m0 and m1 req same cycle after reset -> m0 granted; m0 drops -> IDLE 1 cycle -> m1 granted.
REQ-035 m1 req, ack_i held 0, TIMEOUT=4 -> m1_err_o pulses in 4th OWN1 cycle, IDLE next; m1 not regranted until req low 1 cycle.
REQ-036 TIMEOUT=4, ack_i asserted exactly in 4th cycle -> m1_ack_o 1, no err, tenure continues.
REQ-037 reset_ni low during OWN0 with cyc_o=1 -> next cycle all outputs 0, state IDLE, m0 wins next contested grant.
REQ-038 ack_i pulsed while IDLE or to non-owner -> no mN_ack_o asserted.
